// File: rtl/scan_mux_pkg.sv
// Shared types and default parameters for the scan_mux channel selector.
package scan_mux_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DWELL = 50_000_000;

   // Dwell counter width; a single bit is kept even when DWELL is 1.
   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel word selector with manual select and timed auto-scan.
// Define SCAN_MUX_SYNC_EN to pass sel/auto/hold through two-flop synchronisers.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int WIDTH = DEF_WIDTH,
   parameter int DWELL = DEF_DWELL,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  auto,
   input  logic                  hold,
   output logic [WIDTH-1:0]      dout,
   output logic [SEL_W-1:0]      ch,
   output logic                  chg
);

   localparam int               CNT_W    = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);
   localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);

   logic [SEL_W-1:0] sel_eff;
   logic             auto_eff;
   logic             hold_eff;

`ifdef SCAN_MUX_SYNC_EN
   logic [SEL_W+1:0] sync_q;

   sync2 #(
      .WIDTH (SEL_W + 2)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({sel, auto, hold}),
      .q     (sync_q)
   );

   assign {sel_eff, auto_eff, hold_eff} = sync_q;
`else
   assign sel_eff  = sel;
   assign auto_eff = auto;
   assign hold_eff = hold;
`endif

   logic [WIDTH-1:0] word [N_CH];

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_word
         assign word[gi] = din[gi*WIDTH +: WIDTH];
      end
   endgenerate

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_now;
   logic [CNT_W-1:0] cnt_next;
   logic [SEL_W-1:0] ch_reg;
   logic [SEL_W-1:0] ch_next;
   logic [WIDTH-1:0] dout_reg;
   logic             chg_reg;

   // The mode for this cycle follows the effective auto input, so a falling
   // auto on the terminal count reloads sel instead of advancing.
   always_comb begin
      cnt_now  = (state_reg == AUTO) ? cnt_reg : '0;
      cnt_next = '0;
      ch_next  = ch_reg;
      if (auto_eff) begin
         if (hold_eff) begin
            cnt_next = cnt_now;
         end else if (cnt_now == CNT_LAST) begin
            cnt_next = '0;
            ch_next  = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
         end else begin
            cnt_next = cnt_now + 1'b1;
         end
      end else if ({1'b0, sel_eff} < N_CH_EXT) begin
         ch_next = sel_eff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= MANUAL;
         cnt_reg   <= '0;
         ch_reg    <= '0;
         dout_reg  <= '0;
         chg_reg   <= 1'b0;
      end else begin
         state_reg <= auto_eff ? AUTO : MANUAL;
         cnt_reg   <= cnt_next;
         ch_reg    <= ch_next;
         dout_reg  <= word[ch_next];
         chg_reg   <= (ch_next != ch_reg);
      end
   end

   assign dout = dout_reg;
   assign ch   = ch_reg;
   assign chg  = chg_reg;

endmodule

// File: tb/tb_scan_mux.sv
// Directed self-checking bench for scan_mux: a 4-channel/DWELL=3 and a 3-channel/DWELL=2 instance.
module tb_scan_mux;

`ifdef SCAN_MUX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;

   logic [31:0] din_a;
   logic [1:0]  sel_a;
   logic        auto_a;
   logic        hold_a;
   logic [7:0]  dout_a;
   logic [1:0]  ch_a;
   logic        chg_a;

   logic [23:0] din_b;
   logic [1:0]  sel_b;
   logic        auto_b;
   logic        hold_b;
   logic [7:0]  dout_b;
   logic [1:0]  ch_b;
   logic        chg_b;

   int checks = 0;
   int errors = 0;

   scan_mux #(
      .N_CH  (4),
      .WIDTH (8),
      .DWELL (3)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din_a),
      .sel   (sel_a),
      .auto  (auto_a),
      .hold  (hold_a),
      .dout  (dout_a),
      .ch    (ch_a),
      .chg   (chg_a)
   );

   scan_mux #(
      .N_CH  (3),
      .WIDTH (8),
      .DWELL (2)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din_b),
      .sel   (sel_b),
      .auto  (auto_b),
      .hold  (hold_b),
      .dout  (dout_b),
      .ch    (ch_b),
      .chg   (chg_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Auto-scan from ch=2 with din_a = {D3,C2,B1,A0}, sampled after each edge.
   logic [1:0] seq_ch   [9] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
   logic       seq_chg  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [7:0] seq_dout [9] = '{8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hD3, 8'hA0, 8'hA0, 8'hA0, 8'hB1};

   initial begin
      rst_n  = 1'b0;
      din_a  = 32'h03020100;
      sel_a  = 2'd0;
      auto_a = 1'b0;
      hold_a = 1'b0;
      din_b  = 24'h332211;
      sel_b  = 2'd0;
      auto_b = 1'b0;
      hold_b = 1'b0;

      tick(1);
      chk("rst dout", dout_a, 8'h00);
      chk("rst ch", ch_a, 2'd0);
      chk("rst chg", chg_a, 1'b0);
      chk("rst dout_b", dout_b, 8'h00);

      rst_n = 1'b1;
      tick(1);
      chk("idle chg", chg_a, 1'b0);

      sel_a = 2'd2;
      tick(LAT);
      chk("sel2 ch", ch_a, 2'd2);
      chk("sel2 dout", dout_a, 8'h02);
      chk("sel2 chg", chg_a, 1'b1);
      tick(1);
      chk("sel2 chg once", chg_a, 1'b0);
      chk("sel2 ch kept", ch_a, 2'd2);

      din_a = 32'hD3C2B1A0;
      tick(1);
      chk("din track", dout_a, 8'hC2);
      chk("reload no chg", chg_a, 1'b0);

      auto_a = 1'b1;
      tick(LAT - 1);
      for (int i = 0; i < 9; i++) begin
         tick(1);
         chk($sformatf("scan%0d ch", i), ch_a, seq_ch[i]);
         chk($sformatf("scan%0d chg", i), chg_a, seq_chg[i]);
         chk($sformatf("scan%0d dout", i), dout_a, seq_dout[i]);
      end

      // Hold mid-dwell at ch=1, count 1: five frozen cycles, then one more count.
      tick(1);
      chk("hold pre ch", ch_a, 2'd1);
      hold_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk($sformatf("hold%0d ch", i), ch_a, 2'd1);
         chk($sformatf("hold%0d chg", i), chg_a, 1'b0);
      end
      hold_a = 1'b0;
      tick(1);
      chk("resume ch", ch_a, 2'd1);
      tick(1);
      chk("resume adv ch", ch_a, 2'd2);
      chk("resume adv chg", chg_a, 1'b1);

      // Hold on the terminal-count cycle: no advance, count parked at DWELL-1.
      tick(2);
      chk("tc pre ch", ch_a, 2'd2);
      hold_a = 1'b1;
      tick(2);
      chk("tc hold ch", ch_a, 2'd2);
      chk("tc hold chg", chg_a, 1'b0);
      hold_a = 1'b0;
      tick(1);
      chk("tc release ch", ch_a, 2'd3);
      chk("tc release dout", dout_a, 8'hD3);

      // auto falls on the terminal count with sel=1: manual load wins.
      tick(2);
      chk("simul pre ch", ch_a, 2'd3);
      auto_a = 1'b0;
      sel_a  = 2'd1;
      tick(1);
      chk("simul ch", ch_a, 2'd1);
      chk("simul dout", dout_a, 8'hB1);
      chk("simul chg", chg_a, 1'b1);

      // Three channels: sel=3 is out of range and must be ignored.
      sel_b = 2'd2;
      tick(1);
      chk("b sel2 ch", ch_b, 2'd2);
      chk("b sel2 dout", dout_b, 8'h33);
      chk("b sel2 chg", chg_b, 1'b1);
      sel_b = 2'd3;
      tick(1);
      chk("b sel3 ch", ch_b, 2'd2);
      chk("b sel3 chg", chg_b, 1'b0);
      tick(1);
      chk("b sel3 ch again", ch_b, 2'd2);
      auto_b = 1'b1;
      tick(1);
      chk("b auto ch", ch_b, 2'd2);
      tick(1);
      chk("b wrap ch", ch_b, 2'd0);
      chk("b wrap chg", chg_b, 1'b1);
      chk("b wrap dout", dout_b, 8'h11);
      tick(2);
      chk("b step1 ch", ch_b, 2'd1);
      tick(2);
      chk("b step2 ch", ch_b, 2'd2);

      // Asynchronous reset between edges while dut_a is scanning.
      auto_a = 1'b1;
      tick(3);
      chk("prerst ch", ch_a, 2'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("async dout", dout_a, 8'h00);
      chk("async ch", ch_a, 2'd0);
      chk("async chg", chg_a, 1'b0);
      chk("async ch_b", ch_b, 2'd0);
      tick(1);
      rst_n  = 1'b1;
      auto_a = 1'b0;
      sel_a  = 2'd1;
      tick(LAT - 1);
      chk("post rst ch early", ch_a, 2'd0);
      tick(1);
      chk("post rst ch", ch_a, 2'd1);
      chk("post rst dout", dout_a, 8'hB1);
      chk("post rst chg", chg_a, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
